ex_mem_stage: RTL and testbench

Parametrised, elastic EX→MEM pipeline stage replacing the fixed always-load EX/MEM register. Adds valid/ready flow control with a one-entry skid buffer, so upstream back-pressure is registered. Adds synchronous flush for bubble insertion and, optionally, store byte-lane generation. Sits between the ALU stage and data memory, carrying ALU result, store data, destination register and control.

---
 rtl/ex_mem_pkg.sv | 43 ++++
 rtl/ex_mem_lane_gen.sv | 31 +++
 rtl/ex_mem_stage.sv | 140 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types for the elastic EX->MEM stage: slot state, access sizes and the held entry.
// Byte-lane fields are only meaningful when EX_MEM_STAGE_BYTE_LANE_EN is defined.
package ex_mem_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b10
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam int MAX_XLEN = 64;
  localparam int MAX_BE   = MAX_XLEN / 8;
  localparam int MAX_AW   = 8;

  // Sized for the widest legal build; narrower builds leave the upper bits at zero.
  typedef struct packed {
    logic [MAX_XLEN-1:0] alu;
    logic [MAX_XLEN-1:0] rd2;
    logic [MAX_AW-1:0]   a3;
    logic [2:0]          funct3;
    logic                regwrite;
    logic                memtoreg;
    logic                memwrite;
    logic [MAX_BE-1:0]   be;
    logic                misaligned;
  } payload_t;

  // A double access on a 32-bit datapath is treated as a word.
  function automatic int size_bytes(input logic [1:0] sz, input int xlen);
    case (sz)
      SZ_B:    return 1;
      SZ_H:    return 2;
      SZ_W:    return 4;
      default: return (xlen == 64) ? 8 : 4;
    endcase
  endfunction

endpackage

// File: rtl/ex_mem_lane_gen.sv
// Combinational store byte-enable, lane-aligned write data and misalignment detection.
// Instantiated by ex_mem_stage only when EX_MEM_STAGE_BYTE_LANE_EN is defined.
module ex_mem_lane_gen
  import ex_mem_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int BW   = XLEN / 8,
  localparam int OW   = $clog2(BW)
) (
  input  logic [OW-1:0]   offset,
  input  logic [1:0]      size,
  input  logic [XLEN-1:0] data,
  output logic [BW-1:0]   be,
  output logic [XLEN-1:0] wdata,
  output logic            misaligned
);

  int nbytes;

  // Replicating the low bytes across every lane equals a shift by the offset in the enabled lanes.
  always_comb begin
    nbytes     = size_bytes(size, XLEN);
    misaligned = (int'(offset) % nbytes) != 0;
    be         = misaligned ? '0 : (BW'((1 << nbytes) - 1) << offset);
    wdata      = '0;
    for (int i = 0; i < BW; i++) begin
      wdata[8*i +: 8] = data[8*(i % nbytes) +: 8];
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Elastic EX->MEM register with a one-entry skid buffer, synchronous flush and registered in_ready.
// Define EX_MEM_STAGE_BYTE_LANE_EN to generate store byte lanes and misalignment on the input side.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   alu_exmem_in,
  input  logic [XLEN-1:0]   RD2_exmem_in,
  input  logic [REG_AW-1:0] A3_exmem_in,
  input  logic [2:0]        funct3_exmem_in,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemWriteE,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_exmem_out,
  output logic [XLEN-1:0]   RD2_exmem_out,
  output logic [REG_AW-1:0] A3_exmem_out,
  output logic [2:0]        funct3_exmem_out,
  output logic              RegWriteM,
  output logic              MemtoRegM,
  output logic              MemWriteM,
  output logic [XLEN/8-1:0] be_out,
  output logic              misaligned_out
);

  localparam int BW = XLEN / 8;
  localparam int OW = $clog2(BW);

  state_t        state, next_state;
  payload_t      main_q, skid_q, in_pl;
  logic          in_ready_q;
  logic          accept, consume, valid;
  logic [BW-1:0]   be_gen;
  logic [XLEN-1:0] wdata_gen;
  logic            mis_gen;

`ifdef EX_MEM_STAGE_BYTE_LANE_EN
  ex_mem_lane_gen #(.XLEN(XLEN)) u_lane_gen (
    .offset     (alu_exmem_in[OW-1:0]),
    .size       (funct3_exmem_in[1:0]),
    .data       (RD2_exmem_in),
    .be         (be_gen),
    .wdata      (wdata_gen),
    .misaligned (mis_gen)
  );
`else
  assign be_gen    = '1;
  assign wdata_gen = RD2_exmem_in;
  assign mis_gen   = 1'b0;
`endif

  assign valid   = (state != EMPTY);
  assign accept  = in_valid && in_ready_q;
  assign consume = valid && out_ready;

  // A misaligned entry is stored with its write suppressed so it can never reach memory.
  always_comb begin
    in_pl            = '0;
    in_pl.alu        = MAX_XLEN'(alu_exmem_in);
    in_pl.rd2        = MAX_XLEN'(wdata_gen);
    in_pl.a3         = MAX_AW'(A3_exmem_in);
    in_pl.funct3     = funct3_exmem_in;
    in_pl.regwrite   = RegWriteE;
    in_pl.memtoreg   = MemtoRegE;
    in_pl.memwrite   = MemWriteE && !mis_gen;
    in_pl.be         = MAX_BE'(be_gen);
    in_pl.misaligned = mis_gen;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state != SKID);
    end
  end

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (accept) next_state = FULL;
        FULL: begin
          if (accept && !consume)      next_state = SKID;
          else if (!accept && consume) next_state = EMPTY;
        end
        SKID:    if (consume) next_state = FULL;
        default: next_state = EMPTY;
      endcase
    end
  end

  // Flush only empties the slots; MAIN keeps its contents so payload outputs hold their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      case (state)
        EMPTY: if (accept) main_q <= in_pl;
        FULL: begin
          if (accept && consume) main_q <= in_pl;
          else if (accept)       skid_q <= in_pl;
        end
        SKID:  if (consume) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready         = in_ready_q;
    out_valid        = valid;
    alu_exmem_out    = main_q.alu[XLEN-1:0];
    RD2_exmem_out    = main_q.rd2[XLEN-1:0];
    A3_exmem_out     = main_q.a3[REG_AW-1:0];
    funct3_exmem_out = main_q.funct3;
    RegWriteM        = main_q.regwrite && valid;
    MemtoRegM        = main_q.memtoreg;
    MemWriteM        = main_q.memwrite && valid;
    be_out           = main_q.be[BW-1:0];
    misaligned_out   = main_q.misaligned;
  end

  logic unused_slot_bits;
  assign unused_slot_bits = ^{main_q, skid_q};

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage (XLEN=32); byte-lane expectations follow
// whether EX_MEM_STAGE_BYTE_LANE_EN is defined for the build.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_exmem_in;
  logic [31:0] RD2_exmem_in;
  logic [4:0]  A3_exmem_in;
  logic [2:0]  funct3_exmem_in;
  logic        RegWriteE, MemtoRegE, MemWriteE;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_exmem_out;
  logic [31:0] RD2_exmem_out;
  logic [4:0]  A3_exmem_out;
  logic [2:0]  funct3_exmem_out;
  logic        RegWriteM, MemtoRegM, MemWriteM;
  logic [3:0]  be_out;
  logic        misaligned_out;

  int checks = 0;
  int errors = 0;

  ex_mem_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .alu_exmem_in     (alu_exmem_in),
    .RD2_exmem_in     (RD2_exmem_in),
    .A3_exmem_in      (A3_exmem_in),
    .funct3_exmem_in  (funct3_exmem_in),
    .RegWriteE        (RegWriteE),
    .MemtoRegE        (MemtoRegE),
    .MemWriteE        (MemWriteE),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .alu_exmem_out    (alu_exmem_out),
    .RD2_exmem_out    (RD2_exmem_out),
    .A3_exmem_out     (A3_exmem_out),
    .funct3_exmem_out (funct3_exmem_out),
    .RegWriteM        (RegWriteM),
    .MemtoRegM        (MemtoRegM),
    .MemWriteM        (MemWriteM),
    .be_out           (be_out),
    .misaligned_out   (misaligned_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_entry(input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] a3,
                             input logic [2:0] f3, input logic rw, input logic m2r, input logic mw);
    in_valid        = 1'b1;
    alu_exmem_in    = alu;
    RD2_exmem_in    = rd2;
    A3_exmem_in     = a3;
    funct3_exmem_in = f3;
    RegWriteE       = rw;
    MemtoRegE       = m2r;
    MemWriteE       = mw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid, in_ready, RegWriteM, MemtoRegM, MemWriteM, misaligned_out} !== 6'b010000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 010000",
               {out_valid, in_ready, RegWriteM, MemtoRegM, MemWriteM, misaligned_out});
    end
    checks++;
    if ({alu_exmem_out, RD2_exmem_out, A3_exmem_out, funct3_exmem_out, be_out} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_payload: alu=%h rd2=%h a3=%h f3=%h be=%h expected all zero",
               alu_exmem_out, RD2_exmem_out, A3_exmem_out, funct3_exmem_out, be_out);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL reset_release: valid/ready got %b expected 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive_entry(32'h0000_1004, 32'hDEAD_BEEF, 5'd7, 3'b010, 1'b1, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready, RegWriteM} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL single_ctrl: valid/ready/regwrite got %b expected 111",
               {out_valid, in_ready, RegWriteM});
    end
    checks++;
    if ({alu_exmem_out, RD2_exmem_out, A3_exmem_out} !== {32'h0000_1004, 32'hDEAD_BEEF, 5'd7}) begin
      errors++;
      $display("[TB] FAIL single_payload: alu=%h rd2=%h a3=%0d expected 00001004 deadbeef 7",
               alu_exmem_out, RD2_exmem_out, A3_exmem_out);
    end
    step();
    checks++;
    if ({out_valid, RegWriteM} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL single_drain: valid/regwrite got %b expected 00", {out_valid, RegWriteM});
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive_entry(32'h0000_0100, 32'h0000_000A, 5'd1, 3'b010, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({out_valid, in_ready, alu_exmem_out} !== {2'b11, 32'h0000_0100}) begin
      errors++;
      $display("[TB] FAIL bp_a_main: valid=%b ready=%b alu=%h expected 1 1 00000100",
               out_valid, in_ready, alu_exmem_out);
    end
    drive_entry(32'h0000_0104, 32'h0000_000B, 5'd2, 3'b010, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({in_ready, alu_exmem_out, RD2_exmem_out} !== {1'b0, 32'h0000_0100, 32'h0000_000A}) begin
      errors++;
      $display("[TB] FAIL bp_b_skid: ready=%b alu=%h rd2=%h expected 0 00000100 0000000a",
               in_ready, alu_exmem_out, RD2_exmem_out);
    end
    drive_entry(32'h0000_0108, 32'h0000_000C, 5'd3, 3'b010, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({out_valid, in_ready, alu_exmem_out} !== {2'b10, 32'h0000_0100}) begin
      errors++;
      $display("[TB] FAIL bp_c_blocked: valid=%b ready=%b alu=%h expected 1 0 00000100",
               out_valid, in_ready, alu_exmem_out);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if ({out_valid, in_ready, alu_exmem_out, A3_exmem_out} !== {2'b11, 32'h0000_0104, 5'd2}) begin
      errors++;
      $display("[TB] FAIL bp_deliver_b: valid=%b ready=%b alu=%h a3=%0d expected 1 1 00000104 2",
               out_valid, in_ready, alu_exmem_out, A3_exmem_out);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, alu_exmem_out, RD2_exmem_out} !== {1'b1, 32'h0000_0108, 32'h0000_000C}) begin
      errors++;
      $display("[TB] FAIL bp_deliver_c: valid=%b alu=%h rd2=%h expected 1 00000108 0000000c",
               out_valid, alu_exmem_out, RD2_exmem_out);
    end
    step();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL bp_no_dup: valid/ready got %b expected 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_entry(32'h0000_0200, 32'h0000_1111, 5'd4, 3'b010, 1'b1, 1'b1, 1'b1);
    step();
    drive_entry(32'h0000_0204, 32'h0000_2222, 5'd5, 3'b010, 1'b1, 1'b0, 1'b1);
    step();
    checks++;
    if ({in_ready, MemWriteM, RegWriteM} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL flush_setup: ready/memwrite/regwrite got %b expected 011",
               {in_ready, MemWriteM, RegWriteM});
    end
    drive_entry(32'h0000_02F0, 32'h0000_DDDD, 5'd9, 3'b010, 1'b1, 1'b0, 1'b1);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready, MemWriteM, RegWriteM} !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL flush_empty: valid/ready/memwrite/regwrite got %b expected 0100",
               {out_valid, in_ready, MemWriteM, RegWriteM});
    end
    checks++;
    if (alu_exmem_out !== 32'h0000_0200) begin
      errors++;
      $display("[TB] FAIL flush_hold: alu got %h expected 00000200", alu_exmem_out);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_d_dropped: cycle %0d valid=%b alu=%h expected valid 0",
                 i, out_valid, alu_exmem_out);
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive_entry(32'h0000_0300, 32'h0000_3333, 5'd6, 3'b010, 1'b1, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL areset_setup: valid got %b expected 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, RegWriteM, MemtoRegM, alu_exmem_out} !== {4'b0100, 32'h0}) begin
      errors++;
      $display("[TB] FAIL areset_immediate: valid=%b ready=%b rw=%b m2r=%b alu=%h expected 0 1 0 0 00000000",
               out_valid, in_ready, RegWriteM, MemtoRegM, alu_exmem_out);
    end
    #1 rst_n = 1'b1;
    step();
    checks++;
    if ({out_valid, in_ready, alu_exmem_out, RD2_exmem_out, be_out} !== {2'b01, 68'h0}) begin
      errors++;
      $display("[TB] FAIL areset_hold: valid=%b ready=%b alu=%h rd2=%h be=%h expected 0 1 0 0 0",
               out_valid, in_ready, alu_exmem_out, RD2_exmem_out, be_out);
    end
  endtask

  task automatic test_byte_lane();
    out_ready = 1'b1;
`ifdef EX_MEM_STAGE_BYTE_LANE_EN
    drive_entry(32'h0000_0103, 32'h0000_00AB, 5'd8, 3'b000, 1'b0, 1'b0, 1'b1);
    step();
    checks++;
    if ({be_out, RD2_exmem_out[31:24], misaligned_out, MemWriteM} !== {4'b1000, 8'hAB, 2'b01}) begin
      errors++;
      $display("[TB] FAIL lane_sb: be=%b rd2=%h mis=%b mw=%b expected 1000 AB______ 0 1",
               be_out, RD2_exmem_out, misaligned_out, MemWriteM);
    end
    drive_entry(32'h0000_0101, 32'h0000_1234, 5'd8, 3'b001, 1'b0, 1'b0, 1'b1);
    step();
    checks++;
    if ({out_valid, misaligned_out, be_out, MemWriteM} !== {2'b11, 4'b0000, 1'b0}) begin
      errors++;
      $display("[TB] FAIL lane_sh_misaligned: valid=%b mis=%b be=%b mw=%b expected 1 1 0000 0",
               out_valid, misaligned_out, be_out, MemWriteM);
    end
    drive_entry(32'h0000_0102, 32'h0000_1234, 5'd8, 3'b001, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    checks++;
    if ({be_out, RD2_exmem_out[31:16], misaligned_out, MemWriteM} !== {4'b1100, 16'h1234, 2'b01}) begin
      errors++;
      $display("[TB] FAIL lane_sh_aligned: be=%b rd2=%h mis=%b mw=%b expected 1100 1234____ 0 1",
               be_out, RD2_exmem_out, misaligned_out, MemWriteM);
    end
`else
    drive_entry(32'h0000_0101, 32'h0000_1234, 5'd8, 3'b001, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    checks++;
    if ({be_out, misaligned_out, MemWriteM, RD2_exmem_out} !== {4'hF, 2'b01, 32'h0000_1234}) begin
      errors++;
      $display("[TB] FAIL lane_off_sh: be=%h mis=%b mw=%b rd2=%h expected f 0 1 00001234",
               be_out, misaligned_out, MemWriteM, RD2_exmem_out);
    end
`endif
    step();
    checks++;
    if ({out_valid, MemWriteM} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL lane_drain: valid/memwrite got %b expected 00", {out_valid, MemWriteM});
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive_entry('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    in_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_byte_lane();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
